// File: rtl/ee357_regfile_writer.sv
// Sole write-port owner for the 2R1W register file: clears every register after reset or on
// request, and otherwise merges CPU writeback (priority) with a valid/ready loader stream.
module ee357_regfile_writer #(
  parameter int unsigned ADDR_SIZE = 5,
  parameter int unsigned DATA_SIZE = 32,
  parameter logic [DATA_SIZE-1:0] CLEAR_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_wen,
  input  logic [ADDR_SIZE-1:0] cpu_wa,
  input  logic [DATA_SIZE-1:0] cpu_wdata,
  input  logic                 ld_valid,
  input  logic [ADDR_SIZE-1:0] ld_addr,
  input  logic [DATA_SIZE-1:0] ld_data,
  output logic                 ld_ready,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 clr_done,
  output logic                 err_drop,
  output logic                 rf_wen,
  output logic [ADDR_SIZE-1:0] rf_wa,
  output logic [DATA_SIZE-1:0] rf_wdata
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e               state;
  logic [ADDR_SIZE-1:0] cnt;
  logic                 ld_fire;

  assign busy     = (state == StClear);
  assign ld_ready = (state == StRun) && !cpu_wen && !clr_req;
  assign ld_fire  = ld_valid && ld_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StClear;
      cnt      <= {{(ADDR_SIZE-1){1'b0}}, 1'b1};
      rf_wen   <= 1'b0;
      rf_wa    <= '0;
      rf_wdata <= '0;
      clr_done <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      unique case (state)
        StClear: begin
          rf_wen   <= 1'b1;
          rf_wa    <= cnt;
          rf_wdata <= CLEAR_VALUE;
          // CPU is told to stall via busy; anything it still issues is lost.
          if (cpu_wen) begin
            err_drop <= 1'b1;
          end
          if (cnt == '1) begin
            state    <= StRun;
            cnt      <= {{(ADDR_SIZE-1){1'b0}}, 1'b1};
            clr_done <= 1'b1;
          end else begin
            cnt      <= cnt + 1'b1;
            clr_done <= 1'b0;
          end
        end
        StRun: begin
          clr_done <= 1'b0;
          // Address 0 is hardwired: accept the request but never drive the port.
          if (cpu_wen) begin
            rf_wen <= (cpu_wa != '0);
            if (cpu_wa != '0) begin
              rf_wa    <= cpu_wa;
              rf_wdata <= cpu_wdata;
            end
          end else if (ld_fire) begin
            rf_wen <= (ld_addr != '0);
            if (ld_addr != '0) begin
              rf_wa    <= ld_addr;
              rf_wdata <= ld_data;
            end
          end else begin
            rf_wen <= 1'b0;
          end
          if (clr_req) begin
            state <= StClear;
            cnt   <= {{(ADDR_SIZE-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state <= StClear;
          cnt   <= {{(ADDR_SIZE-1){1'b0}}, 1'b1};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ee357_regfile_writer.sv
// Scoreboard bench for ee357_regfile_writer: expected port writes are queued by the stimulus
// and popped by an independent monitor on every rf_wen cycle.
module tb_ee357_regfile_writer;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] FILL = 32'hA5A5_0000;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_wen = 1'b0;
  logic [AW-1:0] cpu_wa = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          clr_req = 1'b0;
  logic          busy;
  logic          clr_done;
  logic          err_drop;
  logic          rf_wen;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wdata;

  logic          fill = 1'b1;
  logic [DW-1:0] rf [2**AW];
  wr_t           exp_q [$];
  wr_t           mon_e;
  int            tests = 0;
  int            fails = 0;
  int            n;

  ee357_regfile_writer #(
    .ADDR_SIZE  (AW),
    .DATA_SIZE  (DW),
    .CLEAR_VALUE('0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_wen  (cpu_wen),
    .cpu_wa   (cpu_wa),
    .cpu_wdata(cpu_wdata),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .err_drop (err_drop),
    .rf_wen   (rf_wen),
    .rf_wa    (rf_wa),
    .rf_wdata (rf_wdata)
  );

  always #5 clk = ~clk;

  // Register-file model with garbage prefill so the clear sweep is observable.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 2**AW; i++) rf[i] <= FILL + 32'(i);
    end else if (rf_wen) begin
      rf[rf_wa] <= rf_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_sweep();
    for (int i = 1; i < 2**AW; i++) push(AW'(i), '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call while busy; counts edges until the sweep hands back to RUN.
  task automatic wait_sweep();
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 64);
    check("sweep_len", n, 31);
  endtask

  task automatic check_rf_zero();
    for (int i = 1; i < 2**AW; i++) check($sformatf("rf_zero[%0d]", i), rf[i], '0);
    check("rf0_untouched", rf[0], FILL);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rf_wen) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0d data %h, expected no write", rf_wa,
                   rf_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(rf_wa), 32'(mon_e.a));
          check("wr_data", rf_wdata, mon_e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and the power-on sweep
    repeat (2) @(posedge clk);
    #1;
    check("rst_rf_wen", rf_wen, 0);
    check("rst_rf_wa", 32'(rf_wa), 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_busy", busy, 1);
    check("rst_clr_done", clr_done, 0);
    check("rst_err_drop", err_drop, 0);
    check("rst_ld_ready", ld_ready, 0);
    fill = 1'b0;
    rst = 1'b0;
    push_sweep();
    for (int k = 1; k <= 31; k++) begin
      tick();
      check("sweep_busy", busy, (k < 31) ? 1 : 0);
      check("sweep_clr_done", clr_done, (k == 31) ? 1 : 0);
    end
    tick();
    check("clr_done_pulse_end", clr_done, 0);
    check("run_ld_ready", ld_ready, 1);
    check_rf_zero();

    // CPU beats loader in the same cycle
    cpu_wen = 1'b1; cpu_wa = 5'd5; cpu_wdata = 32'hDEAD_BEEF;
    ld_valid = 1'b1; ld_addr = 5'd6; ld_data = 32'h0000_0066;
    #1;
    check("cpu_blocks_ld_ready", ld_ready, 0);
    push(5'd5, 32'hDEAD_BEEF);
    tick();
    cpu_wen = 1'b0;
    #1;
    check("ld_ready_after_cpu", ld_ready, 1);
    push(5'd6, 32'h0000_0066);
    tick();
    ld_valid = 1'b0;

    // Loader burst, then a discarded write to address 0
    for (int i = 1; i <= 4; i++) begin
      ld_valid = 1'b1; ld_addr = AW'(i); ld_data = 32'(i * 32'h11);
      #1;
      check("burst_ld_ready", ld_ready, 1);
      push(AW'(i), 32'(i * 32'h11));
      tick();
    end
    ld_addr = '0; ld_data = 32'h0000_0099;
    #1;
    check("addr0_ld_ready", ld_ready, 1);
    tick();
    ld_valid = 1'b0;
    check("addr0_no_wen", rf_wen, 0);
    tick();
    for (int i = 1; i <= 4; i++) check("burst_rf", rf[i], 32'(i * 32'h11));
    check("rf0_after_ld0", rf[0], FILL);
    check("rf5_cpu", rf[5], 32'hDEAD_BEEF);

    // clr_req with simultaneous CPU write; loader held off for the whole sweep
    cpu_wen = 1'b1; cpu_wa = 5'd7; cpu_wdata = 32'h0000_0077; clr_req = 1'b1;
    ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'h0000_0099;
    #1;
    check("clr_ld_ready", ld_ready, 0);
    push(5'd7, 32'h0000_0077);
    push_sweep();
    tick();
    cpu_wen = 1'b0; clr_req = 1'b0;
    check("clr_busy_start", busy, 1);
    tick();
    check("rf7_written", rf[7], 32'h0000_0077);
    for (int k = 2; k <= 31; k++) begin
      if (k < 31) begin
        check("clr_ld_blocked", ld_ready, 0);
        tick();
      end
    end
    tick();
    check("clr2_done", clr_done, 1);
    check("clr2_ld_ready", ld_ready, 1);
    push(5'd9, 32'h0000_0099);
    tick();
    ld_valid = 1'b0;
    check("rf7_cleared", rf[7], 0);
    check("err_drop_clean", err_drop, 0);

    // CPU write during a sweep is dropped; clr_req mid-sweep ignored
    clr_req = 1'b1;
    push_sweep();
    tick();
    clr_req = 1'b0;
    repeat (3) tick();
    cpu_wen = 1'b1; cpu_wa = 5'd3; cpu_wdata = 32'h0000_0033;
    tick();
    cpu_wen = 1'b0;
    check("err_drop_set", err_drop, 1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (busy && n < 64) begin
      tick();
      n++;
    end
    check("sweep_not_restarted", n, 26);
    tick();
    check("rf3_dropped", rf[3], 0);
    clr_req = 1'b1;
    push_sweep();
    tick();
    clr_req = 1'b0;
    wait_sweep();
    check("err_drop_sticky", err_drop, 1);
    tick();

    // Reset mid-sweep at address 12
    clr_req = 1'b1;
    push_sweep();
    tick();
    clr_req = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("at_addr12", 32'(rf_wa), 12);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_wen", rf_wen, 0);
    check("rst_mid_busy", busy, 1);
    check("rst_mid_err_drop", err_drop, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    push_sweep();
    wait_sweep();
    tick();
    check_rf_zero();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
